// File: rtl/stream_minmax_tracker_pkg.sv
// Shared definitions for the stream min/max tracker slice.
// Holds the FSM state encoding, default widths and the sign-mode bit encoding.
// Imported by the interface, the comparator and the top level.
package stream_minmax_tracker_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;

  // Value of sign_in / out_sign selecting each compare mode.
  localparam logic SIGN_UNSIGNED = 1'b0;
  localparam logic SIGN_SIGNED   = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/stream_minmax_tracker_if.sv
// Sample-in / result-out bundle of the stream min/max tracker.
// slave  : the tracker (consumes samples, produces the frame result).
// master : the environment (produces samples, consumes the frame result).
interface stream_minmax_tracker_if
  import stream_minmax_tracker_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) ();

  // Sample stream
  logic             sign_in;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;

  // Frame result
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_min;
  logic [WIDTH-1:0] out_max;
  logic [CNT_W-1:0] out_count;
  logic             out_all_eq;
  logic             out_sign;
  logic             out_ovf;

  modport slave (
    input  sign_in, in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_min, out_max, out_count,
           out_all_eq, out_sign, out_ovf
  );

  modport master (
    output sign_in, in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_min, out_max, out_count,
           out_all_eq, out_sign, out_ovf
  );

endinterface

// File: rtl/stream_minmax_tracker_cmp.sv
// Purpose: combinational a-vs-b compare in signed or unsigned mode.
// Latency: none (pure combinational).
// Backpressure: not applicable.
// Ports: a, b (WIDTH-bit operands), sign (mode), eq/gt/lt (a relative to b).
module sign_mode_cmp
  import stream_minmax_tracker_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sign,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  logic [WIDTH-1:0] a_bias;
  logic [WIDTH-1:0] b_bias;

  // Flipping the MSB maps two's complement onto offset binary, so one
  // unsigned comparator serves both modes.
  always_comb begin
    a_bias = a;
    b_bias = b;
    if (sign == SIGN_SIGNED) begin
      a_bias[WIDTH-1] = ~a[WIDTH-1];
      b_bias[WIDTH-1] = ~b[WIDTH-1];
    end
    eq = (a == b);
    gt = (a_bias > b_bias);
    lt = (a_bias < b_bias);
  end

endmodule

// File: rtl/stream_minmax_tracker.sv
// Purpose: running min/max/count/all-equal over a framed sample stream.
// Latency: result valid the cycle after the in_last beat is accepted.
// Backpressure: in_ready drops while a result is held; held until out_ready.
// Ports: clk, rst (async, active-high); bus (slave modport) carries the
//   sample stream (sign_in, in_valid/in_ready, in_data, in_last) and the
//   frame result (out_valid/out_ready, out_min, out_max, out_count,
//   out_all_eq, out_sign, out_ovf).
module stream_minmax_tracker
  import stream_minmax_tracker_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  stream_minmax_tracker_if.slave  bus
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] min_q, min_d;
  logic [WIDTH-1:0] max_q, max_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             all_eq_q, all_eq_d;
  logic             sign_q, sign_d;
  logic             ovf_q, ovf_d;

  logic in_ready;
  logic accept;
  logic eq_min, gt_min, lt_min;
  logic eq_max, gt_max, lt_max;
  logic unused_cmp;

  // Ready is a pure decode of registered state.
  assign in_ready = (state_q != HOLD);
  assign accept   = bus.in_valid & in_ready;

  sign_mode_cmp #(.WIDTH(WIDTH)) u_cmp_min (
    .a    (bus.in_data),
    .b    (min_q),
    .sign (sign_q),
    .eq   (eq_min),
    .gt   (gt_min),
    .lt   (lt_min)
  );

  sign_mode_cmp #(.WIDTH(WIDTH)) u_cmp_max (
    .a    (bus.in_data),
    .b    (max_q),
    .sign (sign_q),
    .eq   (eq_max),
    .gt   (gt_max),
    .lt   (lt_max)
  );

  // Only lt against min and gt against max drive updates.
  assign unused_cmp = &{1'b0, gt_min, eq_max, lt_max};

  always_comb begin
    state_d  = state_q;
    min_d    = min_q;
    max_d    = max_q;
    cnt_d    = cnt_q;
    all_eq_d = all_eq_q;
    sign_d   = sign_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          min_d    = bus.in_data;
          max_d    = bus.in_data;
          cnt_d    = CNT_W'(1);
          all_eq_d = 1'b1;
          ovf_d    = 1'b0;
          sign_d   = bus.sign_in;
          state_d  = bus.in_last ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          if (lt_min) min_d = bus.in_data;
          if (gt_max) max_d = bus.in_data;
          // Judged against the pre-update min.
          all_eq_d = all_eq_q & eq_min;
          if (cnt_q == CNT_MAX) begin
            ovf_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          if (bus.in_last) state_d = HOLD;
        end
      end
      HOLD: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      min_q    <= '0;
      max_q    <= '0;
      cnt_q    <= '0;
      all_eq_q <= 1'b0;
      sign_q   <= SIGN_UNSIGNED;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      min_q    <= min_d;
      max_q    <= max_d;
      cnt_q    <= cnt_d;
      all_eq_q <= all_eq_d;
      sign_q   <= sign_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = (state_q == HOLD);
  assign bus.out_min    = min_q;
  assign bus.out_max    = max_q;
  assign bus.out_count  = cnt_q;
  assign bus.out_all_eq = all_eq_q;
  assign bus.out_sign   = sign_q;
  assign bus.out_ovf    = ovf_q;

endmodule

// File: tb/tb_stream_minmax_tracker.sv
// Directed bench: two trackers (CNT_W=8 and CNT_W=2) with scoreboard monitors.
// Inputs change 2 time units after the rising edge; outputs are read on the
// falling edge.
module tb_stream_minmax_tracker;

  typedef struct packed {
    logic [3:0] mn;
    logic [3:0] mx;
    logic [7:0] cnt;
    logic       eq;
    logic       sg;
    logic       ovf;
  } res_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  res_t q8[$];
  res_t q2[$];

  stream_minmax_tracker_if #(.WIDTH(4), .CNT_W(8)) if8 ();
  stream_minmax_tracker_if #(.WIDTH(4), .CNT_W(2)) if2 ();

  stream_minmax_tracker #(.WIDTH(4), .CNT_W(8)) dut8 (.clk(clk), .rst(rst), .bus(if8));
  stream_minmax_tracker #(.WIDTH(4), .CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitors: every cycle a result is presented it must match
  // the queue head; the head retires on the handshake.
  always @(negedge clk) begin
    if (!rst && if8.out_valid) begin
      n_cmp++;
      if (q8.size() == 0) begin
        n_err++;
        $display("FAIL out8_unexpected: got out_valid=1 expected no result");
      end else begin
        res_t got;
        got = '{if8.out_min, if8.out_max, if8.out_count, if8.out_all_eq,
                if8.out_sign, if8.out_ovf};
        if (got !== q8[0]) begin
          n_err++;
          $display("FAIL out8_result: got %h expected %h", got, q8[0]);
        end
        if (if8.out_ready) void'(q8.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && if2.out_valid) begin
      n_cmp++;
      if (q2.size() == 0) begin
        n_err++;
        $display("FAIL out2_unexpected: got out_valid=1 expected no result");
      end else begin
        res_t got;
        got = '{if2.out_min, if2.out_max, {6'd0, if2.out_count}, if2.out_all_eq,
                if2.out_sign, if2.out_ovf};
        if (got !== q2[0]) begin
          n_err++;
          $display("FAIL out2_result: got %h expected %h", got, q2[0]);
        end
        if (if2.out_ready) void'(q2.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Presents one beat and returns 2 units after the edge that accepted it.
  task automatic beat8(input logic [3:0] d, input logic l, input logic s);
    int n;
    n = 0;
    if8.in_valid = 1'b1;
    if8.in_data  = d;
    if8.in_last  = l;
    if8.sign_in  = s;
    @(negedge clk);
    while (!if8.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("beat8_timeout", 32'(n), 32'd0);
    step();
    if8.in_valid = 1'b0;
  endtask

  task automatic beat2(input logic [3:0] d, input logic l, input logic s);
    int n;
    n = 0;
    if2.in_valid = 1'b1;
    if2.in_data  = d;
    if2.in_last  = l;
    if2.sign_in  = s;
    @(negedge clk);
    while (!if2.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("beat2_timeout", 32'(n), 32'd0);
    step();
    if2.in_valid = 1'b0;
  endtask

  // Called right after the in_last beat: result must be up one cycle later
  // and gone the cycle after the handshake.
  task automatic close8(input string name);
    at_neg();
    chk({name, "_valid_rise"}, 32'(if8.out_valid), 32'd1);
    step();
    at_neg();
    chk({name, "_valid_fall"}, 32'(if8.out_valid), 32'd0);
    step();
  endtask

  task automatic close2(input string name);
    at_neg();
    chk({name, "_valid_rise"}, 32'(if2.out_valid), 32'd1);
    step();
    at_neg();
    chk({name, "_valid_fall"}, 32'(if2.out_valid), 32'd0);
    step();
  endtask

  initial begin
    int n;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    if8.in_valid = 1'b0; if8.in_data = '0; if8.in_last = 1'b0;
    if8.sign_in  = 1'b0; if8.out_ready = 1'b1;
    if2.in_valid = 1'b0; if2.in_data = '0; if2.in_last = 1'b0;
    if2.sign_in  = 1'b0; if2.out_ready = 1'b1;

    // Reset state
    at_neg();
    chk("rst_in_ready",  32'(if8.in_ready),   32'd1);
    chk("rst_out_valid", 32'(if8.out_valid),  32'd0);
    chk("rst_min",       32'(if8.out_min),    32'd0);
    chk("rst_max",       32'(if8.out_max),    32'd0);
    chk("rst_count",     32'(if8.out_count),  32'd0);
    chk("rst_flags",     {29'd0, if8.out_all_eq, if8.out_sign, if8.out_ovf}, 32'd0);
    step();
    rst = 1'b0;
    step();

    // 1: unsigned frame
    q8.push_back('{4'h0, 4'hC, 8'd4, 1'b0, 1'b0, 1'b0});
    beat8(4'h3, 1'b0, 1'b0);
    beat8(4'hC, 1'b0, 1'b0);
    beat8(4'h0, 1'b0, 1'b0);
    beat8(4'h7, 1'b1, 1'b0);
    close8("t1");

    // 2: signed frame; -4 is the minimum
    q8.push_back('{4'hC, 4'h3, 8'd3, 1'b0, 1'b1, 1'b0});
    beat8(4'h3, 1'b0, 1'b1);
    beat8(4'hC, 1'b0, 1'b0);
    beat8(4'h0, 1'b1, 1'b1);
    close8("t2");

    // 3+4: single-beat signed frame held under backpressure while sign_in
    // toggles and a new beat waits
    if8.out_ready = 1'b0;
    q8.push_back('{4'hF, 4'hF, 8'd1, 1'b1, 1'b1, 1'b0});
    beat8(4'hF, 1'b1, 1'b1);
    at_neg();
    chk("t3_valid_rise", 32'(if8.out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      if8.in_valid = 1'b1;
      if8.in_data  = 4'h5;
      if8.in_last  = 1'b1;
      if8.sign_in  = i[0];
      at_neg();
      chk("t4_in_ready_hold", 32'(if8.in_ready), 32'd0);
    end
    step();
    if8.sign_in   = 1'b0;
    if8.out_ready = 1'b1;
    q8.push_back('{4'h5, 4'h5, 8'd1, 1'b1, 1'b0, 1'b0});
    at_neg();
    step();
    at_neg();
    chk("t4_valid_after_hs", 32'(if8.out_valid), 32'd0);
    chk("t4_ready_after_hs", 32'(if8.in_ready),  32'd1);
    step();
    if8.in_valid = 1'b0;
    close8("t4_next");

    // 5: asynchronous reset mid-frame
    beat8(4'h5, 1'b0, 1'b0);
    beat8(4'h6, 1'b0, 1'b0);
    #1 rst = 1'b1;
    #1;
    chk("t5_in_ready", 32'(if8.in_ready),  32'd1);
    chk("t5_valid",    32'(if8.out_valid), 32'd0);
    chk("t5_min",      32'(if8.out_min),   32'd0);
    chk("t5_max",      32'(if8.out_max),   32'd0);
    chk("t5_count",    32'(if8.out_count), 32'd0);
    rst = 1'b0;
    step();
    q8.push_back('{4'h2, 4'h2, 8'd1, 1'b1, 1'b0, 1'b0});
    beat8(4'h2, 1'b1, 1'b0);
    close8("t5_next");

    // 6: saturating count on the 2-bit counter, cleared by the next frame
    q2.push_back('{4'hA, 4'hA, 8'd3, 1'b1, 1'b0, 1'b1});
    for (int i = 0; i < 5; i++) beat2(4'hA, (i == 4), 1'b0);
    close2("t6");
    q2.push_back('{4'h1, 4'hA, 8'd2, 1'b0, 1'b0, 1'b0});
    beat2(4'hA, 1'b0, 1'b0);
    beat2(4'h1, 1'b1, 1'b0);
    close2("t6_next");

    n = 0;
    while ((q8.size() + q2.size()) != 0 && n < 50) begin
      at_neg();
      n++;
    end
    chk("scoreboard_drained", 32'(q8.size() + q2.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
